// File: rtl/mapper_pkg.sv
// Shared types, I/Q level constants and per-mode helpers for the multimode symbol mapper.
package mapper_pkg;

  typedef enum logic [1:0] {
    MODE_BPSK  = 2'd0,
    MODE_QPSK  = 2'd1,
    MODE_QAM16 = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  localparam logic signed [2:0] LVL_P3 = 3'sd3;
  localparam logic signed [2:0] LVL_P1 = 3'sd1;
  localparam logic signed [2:0] LVL_M1 = -3'sd1;
  localparam logic signed [2:0] LVL_M3 = -3'sd3;

  function automatic logic [2:0] bits_per_sym(input mode_t m);
    case (m)
      MODE_BPSK:  return 3'd1;
      MODE_QAM16: return 3'd4;
      default:    return 3'd2;
    endcase
  endfunction

  // Per-axis Gray mapping for 16-QAM: adjacent levels differ in one bit.
  function automatic logic signed [2:0] gray_level(input logic [1:0] b);
    case (b)
      2'b00:   return LVL_P3;
      2'b01:   return LVL_P1;
      2'b11:   return LVL_M1;
      default: return LVL_M3;
    endcase
  endfunction

endpackage

// File: rtl/multimode_symbol_mapper_lut.sv
// Combinational symbol-bits to I/Q level lookup; symbol bits are left-aligned in i_bits.
module symbol_lut
  import mapper_pkg::*;
#(
  parameter int LEVEL_W = 3
) (
  input  mode_t                     i_mode,
  input  logic [3:0]                i_bits,
  output logic signed [LEVEL_W-1:0] o_i,
  output logic signed [LEVEL_W-1:0] o_q
);

  logic signed [2:0] w_i3;
  logic signed [2:0] w_q3;

  always_comb begin
    w_i3 = LVL_P1;
    w_q3 = '0;
    case (i_mode)
      MODE_BPSK: begin
        w_i3 = i_bits[3] ? LVL_M1 : LVL_P1;
        w_q3 = '0;
      end
      MODE_QAM16: begin
        w_i3 = gray_level(i_bits[3:2]);
        w_q3 = gray_level(i_bits[1:0]);
      end
      default: begin
        w_i3 = i_bits[3] ? LVL_M1 : LVL_P1;
        w_q3 = i_bits[2] ? LVL_M1 : LVL_P1;
      end
    endcase
  end

  assign o_i = LEVEL_W'(w_i3);
  assign o_q = LEVEL_W'(w_q3);

endmodule

// File: rtl/multimode_symbol_mapper.sv
// Serialises one frame into BPSK/QPSK/16-QAM symbols, MSB first, with valid/ready output flow control.
module multimode_symbol_mapper
  import mapper_pkg::*;
#(
  parameter int FRAME_BITS = 21,
  parameter int LEVEL_W    = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [FRAME_BITS-1:0]     frame_data,
  input  logic [1:0]                frame_mode,
  input  logic                      frame_valid,
  output logic                      frame_ready,
  output logic signed [LEVEL_W-1:0] sym_i,
  output logic signed [LEVEL_W-1:0] sym_q,
  output logic                      sym_valid,
  input  logic                      sym_ready,
  output logic                      frame_done,
  output logic                      mode_err
);

  localparam int PAD_W    = ((FRAME_BITS + 3) / 4) * 4;
  localparam int CNT_W    = $clog2(FRAME_BITS + 1);
  localparam int NSYM_B   = FRAME_BITS;
  localparam int NSYM_Q   = (FRAME_BITS + 1) / 2;
  localparam int NSYM_16  = (FRAME_BITS + 3) / 4;

  state_t             r_state;
  mode_t              r_mode;
  logic [PAD_W-1:0]   r_shift;
  logic [CNT_W-1:0]   r_cnt;

  mode_t              w_in_mode;
  mode_t              w_eff_mode;
  mode_t              w_lut_mode;
  logic [PAD_W-1:0]   w_frame_pad;
  logic [PAD_W-1:0]   w_next_shift;
  logic [3:0]         w_first_bits;
  logic [3:0]         w_lut_bits;
  logic [CNT_W-1:0]   w_nsym_m1;
  logic signed [LEVEL_W-1:0] w_lut_i;
  logic signed [LEVEL_W-1:0] w_lut_q;

  assign w_in_mode   = mode_t'(frame_mode);
  assign w_eff_mode  = (w_in_mode == MODE_RSVD) ? MODE_QPSK : w_in_mode;
  assign w_frame_pad = PAD_W'(frame_data) << (PAD_W - FRAME_BITS);
  assign w_next_shift = r_shift << bits_per_sym(r_mode);

  generate
    if (FRAME_BITS >= 4) begin : g_wide
      assign w_first_bits = frame_data[FRAME_BITS-1 -: 4];
    end else begin : g_narrow
      assign w_first_bits = 4'(frame_data) << (4 - FRAME_BITS);
    end
  endgenerate

  always_comb begin
    w_nsym_m1 = CNT_W'(NSYM_Q - 1);
    case (w_eff_mode)
      MODE_BPSK:  w_nsym_m1 = CNT_W'(NSYM_B - 1);
      MODE_QAM16: w_nsym_m1 = CNT_W'(NSYM_16 - 1);
      default:    w_nsym_m1 = CNT_W'(NSYM_Q - 1);
    endcase
  end

  // In IDLE the LUT looks at the incoming frame; in SEND it looks one symbol ahead
  // so the next symbol is registered on the same edge as the handshake.
  assign w_lut_mode = (r_state == IDLE) ? w_eff_mode : r_mode;
  assign w_lut_bits = (r_state == IDLE) ? w_first_bits : w_next_shift[PAD_W-1 -: 4];

  symbol_lut #(.LEVEL_W(LEVEL_W)) u_lut (
    .i_mode (w_lut_mode),
    .i_bits (w_lut_bits),
    .o_i    (w_lut_i),
    .o_q    (w_lut_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_mode      <= MODE_BPSK;
      r_shift     <= '0;
      r_cnt       <= '0;
      frame_ready <= 1'b1;
      sym_valid   <= 1'b0;
      sym_i       <= '0;
      sym_q       <= '0;
      frame_done  <= 1'b0;
      mode_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          frame_done <= 1'b0;
          mode_err   <= 1'b0;
          if (frame_valid && frame_ready) begin
            r_state     <= SEND;
            r_mode      <= w_eff_mode;
            r_shift     <= w_frame_pad;
            r_cnt       <= w_nsym_m1;
            frame_ready <= 1'b0;
            sym_valid   <= 1'b1;
            sym_i       <= w_lut_i;
            sym_q       <= w_lut_q;
            mode_err    <= (w_in_mode == MODE_RSVD);
          end
        end
        SEND: begin
          mode_err <= 1'b0;
          if (sym_valid && sym_ready) begin
            if (r_cnt == '0) begin
              r_state    <= DONE;
              sym_valid  <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              r_shift <= w_next_shift;
              r_cnt   <= r_cnt - 1'b1;
              sym_i   <= w_lut_i;
              sym_q   <= w_lut_q;
            end
          end
        end
        DONE: begin
          r_state     <= IDLE;
          frame_done  <= 1'b0;
          frame_ready <= 1'b1;
        end
        default: begin
          r_state     <= IDLE;
          frame_ready <= 1'b1;
          sym_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multimode_symbol_mapper.sv
// Directed self-checking bench for multimode_symbol_mapper with a small reference mapping model.
module tb_multimode_symbol_mapper;

  logic        clk = 1'b0;
  logic        reset;
  logic [20:0] frame_data;
  logic [1:0]  frame_mode;
  logic        frame_valid;
  logic        frame_ready;
  logic signed [2:0] sym_i;
  logic signed [2:0] sym_q;
  logic        sym_valid;
  logic        sym_ready;
  logic        frame_done;
  logic        mode_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multimode_symbol_mapper #(.FRAME_BITS(21), .LEVEL_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_data  (frame_data),
    .frame_mode  (frame_mode),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .sym_i       (sym_i),
    .sym_q       (sym_q),
    .sym_valid   (sym_valid),
    .sym_ready   (sym_ready),
    .frame_done  (frame_done),
    .mode_err    (mode_err)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int gray(input logic a, input logic b);
    case ({a, b})
      2'b00:   return 3;
      2'b01:   return 1;
      2'b11:   return -1;
      default: return -3;
    endcase
  endfunction

  // Expected level of symbol k: frame padded to 24 bits, symbol bits read by position.
  function automatic int exp_lvl(input logic [20:0] d, input int m, input int k, input bit q);
    logic [23:0] p;
    int t;
    p = {d, 3'b000};
    if (m == 0) begin
      t = 23 - k;
      return q ? 0 : (p[t] ? -1 : 1);
    end else if (m == 2) begin
      t = 23 - 4 * k;
      return q ? gray(p[t-2], p[t-3]) : gray(p[t], p[t-1]);
    end else begin
      t = 23 - 2 * k;
      return q ? (p[t-1] ? -1 : 1) : (p[t] ? -1 : 1);
    end
  endfunction

  task automatic run_frame(input logic [20:0] d, input int m, input int nsym, input bit stall,
                           input int abort_k, input bit hold, input logic [20:0] nd, input int nm);
    int  k;
    int  cyc;
    bit  got;
    frame_data  = d;
    frame_mode  = 2'(m);
    frame_valid = 1'b1;
    got = 1'b0;
    for (int w = 0; w < 50 && !got; w++) begin
      if (frame_ready) got = 1'b1;
      else @(negedge clk);
    end
    chk("accept", 32'(got), 1);
    @(negedge clk);
    frame_data  = nd;
    frame_mode  = 2'(nm);
    frame_valid = hold;
    chk("mode_err", mode_err, (m == 3) ? 1 : 0);
    chk("ready_low", frame_ready, 0);
    k = 0;
    cyc = 0;
    while (k < nsym && cyc < 500) begin
      if (abort_k != 0 && k == abort_k) return;
      sym_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      chk($sformatf("valid k%0d", k), sym_valid, 1);
      chk($sformatf("no_done k%0d", k), frame_done, 0);
      if (cyc > 0) chk($sformatf("err_clr k%0d", k), mode_err, 0);
      if (sym_valid) begin
        chk($sformatf("sym_i k%0d", k), $signed(sym_i), exp_lvl(d, m, k, 1'b0));
        chk($sformatf("sym_q k%0d", k), $signed(sym_q), exp_lvl(d, m, k, 1'b1));
        if (sym_ready) k++;
      end
      @(negedge clk);
      cyc++;
    end
    sym_ready = 1'b1;
    chk("sym_count", k, nsym);
    chk("done_pulse", frame_done, 1);
    chk("valid_drop", sym_valid, 0);
    chk("ready_in_done", frame_ready, 0);
    @(negedge clk);
    chk("done_clear", frame_done, 0);
    chk("ready_back", frame_ready, 1);
  endtask

  initial begin
    reset       = 1'b1;
    frame_data  = '0;
    frame_mode  = 2'd0;
    frame_valid = 1'b0;
    sym_ready   = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", frame_ready, 1);
    chk("rst_valid", sym_valid, 0);
    chk("rst_i", $signed(sym_i), 0);
    chk("rst_q", $signed(sym_q), 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err", mode_err, 0);

    // QPSK: first (-1,-1), last (+1,+1) from padded tail; inputs scrambled mid-frame.
    run_frame(21'h1AAAAA, 1, 11, 1'b0, 0, 1'b0, 21'h055555, 2);
    // 16-QAM: five (+3,+3) then (-3,+3).
    run_frame(21'h000001, 2, 6, 1'b0, 0, 1'b0, 21'h1FFFFF, 0);
    // BPSK with random downstream stalls.
    run_frame(21'h155555, 0, 21, 1'b1, 0, 1'b0, 21'h0AAAAA, 1);

    // Reset after the third QPSK symbol has been accepted.
    run_frame(21'h0F0F0F, 1, 11, 1'b0, 3, 1'b0, 21'h000000, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_valid", sym_valid, 0);
    chk("abort_done", frame_done, 0);
    chk("abort_ready", frame_ready, 1);
    @(negedge clk);
    chk("abort_done2", frame_done, 0);
    run_frame(21'h012345, 1, 11, 1'b0, 0, 1'b0, 21'h1E1E1E, 0);

    // Reserved mode maps as QPSK; valid held so the next frame goes straight in.
    run_frame(21'h0ABCDE, 3, 11, 1'b0, 0, 1'b1, 21'h01C3A5, 1);
    run_frame(21'h01C3A5, 1, 11, 1'b1, 0, 1'b0, 21'h000000, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
